// File: rtl/compl_mul_pipe.sv
// Three-stage pipelined complex multiplier: a*b or a*conj(b) on signed I/Q samples,
// with half-up or convergent rounding, output saturation and a single global stall enable.
module compl_mul_pipe #(
  parameter int DATA_W = 18,
  parameter int OUT_W  = DATA_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic              s_conj_i,
  input  logic              s_round_i,
  input  logic [DATA_W-1:0] data_a_i_i,
  input  logic [DATA_W-1:0] data_a_q_i,
  input  logic [DATA_W-1:0] data_b_i_i,
  input  logic [DATA_W-1:0] data_b_q_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [OUT_W-1:0]  data_i_o,
  output logic [OUT_W-1:0]  data_q_o,
  output logic              sat_o
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + 2;
  localparam int F  = DATA_W - 1;
  localparam int RW = SW - F;
  localparam logic [SW-1:0] HALF = SW'(1) << (F - 1);

  // Handshake: input moves on s_valid_i && s_ready_o, output on m_valid_o && m_ready_i;
  // the whole pipe advances together whenever the output slot is empty or being drained.
  logic w_en;

  logic                     r_s1_valid, r_s1_conj, r_s1_round;
  logic signed [DATA_W-1:0] r_s1_ai, r_s1_aq, r_s1_bi, r_s1_bq;

  logic                 r_s2_valid, r_s2_conj, r_s2_round;
  logic signed [PW-1:0] r_s2_pii, r_s2_pqq, r_s2_pqi, r_s2_piq;

  logic                 r_s3_valid, r_sat;
  logic [OUT_W-1:0]     r_data_i, r_data_q;

  logic signed [SW-1:0] w_pii, w_pqq, w_pqi, w_piq;
  logic signed [SW-1:0] w_sum_i, w_sum_q;
  logic [OUT_W:0]       w_rs_i, w_rs_q;

  // Returns {saturated, value}; RW is always wider than OUT_W so the clamp test is a sign check.
  function automatic logic [OUT_W:0] round_sat(input logic signed [SW-1:0] s, input logic conv);
    logic signed [RW-1:0] r;
    logic                 tie;
    logic                 sat;
    logic [OUT_W-1:0]     v;
    r   = RW'((s + $signed(HALF)) >>> F);
    tie = (s[F-1:0] == HALF[F-1:0]);
    if (conv && tie) r[0] = 1'b0;
    sat = !((&r[RW-1:OUT_W-1]) || !(|r[RW-1:OUT_W-1]));
    v   = sat ? {r[RW-1], {(OUT_W-1){~r[RW-1]}}} : r[OUT_W-1:0];
    return {sat, v};
  endfunction

  assign w_en      = !r_s3_valid || m_ready_i;
  assign s_ready_o = w_en;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_valid <= 1'b0;
      r_s1_conj  <= 1'b0;
      r_s1_round <= 1'b0;
      r_s1_ai    <= '0;
      r_s1_aq    <= '0;
      r_s1_bi    <= '0;
      r_s1_bq    <= '0;
    end else if (w_en) begin
      r_s1_valid <= s_valid_i;
      r_s1_conj  <= s_conj_i;
      r_s1_round <= s_round_i;
      r_s1_ai    <= data_a_i_i;
      r_s1_aq    <= data_a_q_i;
      r_s1_bi    <= data_b_i_i;
      r_s1_bq    <= data_b_q_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s2_valid <= 1'b0;
      r_s2_conj  <= 1'b0;
      r_s2_round <= 1'b0;
      r_s2_pii   <= '0;
      r_s2_pqq   <= '0;
      r_s2_pqi   <= '0;
      r_s2_piq   <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_conj  <= r_s1_conj;
      r_s2_round <= r_s1_round;
      r_s2_pii   <= PW'(r_s1_ai) * PW'(r_s1_bi);
      r_s2_pqq   <= PW'(r_s1_aq) * PW'(r_s1_bq);
      r_s2_pqi   <= PW'(r_s1_aq) * PW'(r_s1_bi);
      r_s2_piq   <= PW'(r_s1_ai) * PW'(r_s1_bq);
    end
  end

  // Conjugation lives in the add/subtract choice so -2^(DATA_W-1) never has to be negated.
  assign w_pii   = SW'(r_s2_pii);
  assign w_pqq   = SW'(r_s2_pqq);
  assign w_pqi   = SW'(r_s2_pqi);
  assign w_piq   = SW'(r_s2_piq);
  assign w_sum_i = r_s2_conj ? (w_pii + w_pqq) : (w_pii - w_pqq);
  assign w_sum_q = r_s2_conj ? (w_pqi - w_piq) : (w_piq + w_pqi);
  assign w_rs_i  = round_sat(w_sum_i, r_s2_round);
  assign w_rs_q  = round_sat(w_sum_q, r_s2_round);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s3_valid <= 1'b0;
      r_data_i   <= '0;
      r_data_q   <= '0;
      r_sat      <= 1'b0;
    end else if (w_en) begin
      r_s3_valid <= r_s2_valid;
      r_data_i   <= w_rs_i[OUT_W-1:0];
      r_data_q   <= w_rs_q[OUT_W-1:0];
      r_sat      <= w_rs_i[OUT_W] | w_rs_q[OUT_W];
    end
  end

  assign m_valid_o = r_s3_valid;
  assign data_i_o  = r_data_i;
  assign data_q_o  = r_data_q;
  assign sat_o     = r_sat;

endmodule

// File: tb/tb_compl_mul_pipe.sv
// Bench for compl_mul_pipe: directed corner cases plus randomized traffic with random
// backpressure, scored in order against an integer-arithmetic reference model.
module tb_compl_mul_pipe;

  localparam int DW = 18;
  localparam int OW = DW + 1;
  localparam int EW = 1 + 2 * OW;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          s_valid_i, s_ready_o, s_conj_i, s_round_i;
  logic [DW-1:0] data_a_i_i, data_a_q_i, data_b_i_i, data_b_q_i;
  logic          m_valid_o, m_ready_i;
  logic [OW-1:0] data_i_o, data_q_o;
  logic          sat_o;

  compl_mul_pipe #(.DATA_W(DW), .OUT_W(OW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_conj_i(s_conj_i), .s_round_i(s_round_i),
    .data_a_i_i(data_a_i_i), .data_a_q_i(data_a_q_i),
    .data_b_i_i(data_b_i_i), .data_b_q_i(data_b_q_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .data_i_o(data_i_o), .data_q_o(data_q_o), .sat_o(sat_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            cyc_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            last_stall = -1;
  logic          held_v = 1'b0;
  logic [EW-1:0] held_val;
  logic          in_fire;

  // staged stimulus, applied at the next falling edge
  logic          st_valid = 1'b0, st_mready = 1'b1, st_conj = 1'b0, st_round = 1'b0;
  logic [DW-1:0] st_ai = '0, st_aq = '0, st_bi = '0, st_bq = '0;
  logic          st_dir = 1'b0;
  logic [EW-1:0] st_exp = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint rnd_shift(input longint s, input logic conv);
    longint f, h, r;
    f = 64'sd1 <<< (DW - 1);
    h = f / 2;
    r = (s + h) >>> (DW - 1);
    // exact tie: half-up picked the upper neighbour; convergent wants the even one
    if (conv && ((s & (f - 1)) == h) && (r % 2 != 0)) r = r - 1;
    return r;
  endfunction

  function automatic logic [EW-1:0] model(input logic [DW-1:0] ai, aq, bi, bq,
                                          input logic conj, input logic conv);
    longint xai, xaq, xbi, xbq, si, sq, ri, rq, hi, lo;
    logic   sat;
    logic [OW-1:0] oi, oq;
    xai = longint'($signed(ai)); xaq = longint'($signed(aq));
    xbi = longint'($signed(bi)); xbq = longint'($signed(bq));
    // a*conj(b) = (ai*bi + aq*bq) + j(aq*bi - ai*bq)
    si = conj ? xai * xbi + xaq * xbq : xai * xbi - xaq * xbq;
    sq = conj ? xaq * xbi - xai * xbq : xai * xbq + xaq * xbi;
    ri = rnd_shift(si, conv);
    rq = rnd_shift(sq, conv);
    hi = (64'sd1 <<< (OW - 1)) - 1;
    lo = -(64'sd1 <<< (OW - 1));
    sat = 1'b0;
    if (ri > hi) begin ri = hi; sat = 1'b1; end
    if (ri < lo) begin ri = lo; sat = 1'b1; end
    if (rq > hi) begin rq = hi; sat = 1'b1; end
    if (rq < lo) begin rq = lo; sat = 1'b1; end
    oi = OW'(ri);
    oq = OW'(rq);
    return {sat, oi, oq};
  endfunction

  // ---------------- driver + monitor, one clock per call ----------------
  task automatic cycle();
    logic [EW-1:0] e;
    int c;
    @(negedge clk_i);
    s_valid_i  = st_valid;
    s_conj_i   = st_conj;
    s_round_i  = st_round;
    data_a_i_i = st_ai;
    data_a_q_i = st_aq;
    data_b_i_i = st_bi;
    data_b_q_i = st_bq;
    m_ready_i  = st_mready;
    cyc++;
    #1;
    if (held_v) chk("hold", {sat_o, data_i_o, data_q_o}, held_val);
    held_v = m_valid_o && !m_ready_i;
    if (held_v) begin
      held_val   = {sat_o, data_i_o, data_q_o};
      last_stall = cyc;
      chk("ready_stall", s_ready_o, 0);
    end else begin
      chk("ready_open", s_ready_o, 1);
    end
    in_fire = s_valid_i && s_ready_o;
    if (in_fire) begin
      exp_q.push_back(st_dir ? st_exp
                             : model(data_a_i_i, data_a_q_i, data_b_i_i, data_b_q_i,
                                     s_conj_i, s_round_i));
      cyc_q.push_back(cyc);
    end
    if (m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", {sat_o, data_i_o, data_q_o}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        chk("out", {sat_o, data_i_o, data_q_o}, e);
        if (c > last_stall) chk("latency", 64'(cyc - c), 3);
      end
    end
  endtask

  task automatic idle(input int n);
    st_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input logic [DW-1:0] ai, aq, bi, bq, input logic c, r,
                      input logic [OW-1:0] ei, eq, input logic es);
    st_ai = ai; st_aq = aq; st_bi = bi; st_bq = bq;
    st_conj = c; st_round = r;
    st_dir = 1'b1; st_exp = {es, ei, eq};
    st_valid = 1'b1;
    cycle();
    st_valid = 1'b0;
    st_dir = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_op();
    case ($urandom_range(0, 9))
      0:       return 18'h20000;
      1:       return 18'h1FFFF;
      default: return DW'($urandom());
    endcase
  endfunction

  task automatic rand_stage();
    st_ai = rnd_op(); st_aq = rnd_op(); st_bi = rnd_op(); st_bq = rnd_op();
    st_conj = 1'($urandom_range(0, 1));
    st_round = 1'($urandom_range(0, 1));
    st_dir = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int sent;
    rst_n_i = 1'b0;
    s_valid_i = 1'b0; s_conj_i = 1'b0; s_round_i = 1'b0; m_ready_i = 1'b1;
    data_a_i_i = '0; data_a_q_i = '0; data_b_i_i = '0; data_b_q_i = '0;
    repeat (3) @(negedge clk_i);
    #2 rst_n_i = 1'b1;
    #1;
    chk("rst_valid", m_valid_o, 0);
    chk("rst_data", {sat_o, data_i_o, data_q_o}, 0);
    idle(2);

    // basic product and latency
    send(18'h10000, 0, 18'h10000, 0, 0, 0, 19'd32768, 0, 0);
    idle(4);

    // rounding ties
    send(18'h00001, 0, 18'h10000, 0, 0, 0, 19'd1, 0, 0);
    send(18'h00001, 0, 18'h10000, 0, 0, 1, 19'd0, 0, 0);
    send(18'h00003, 0, 18'h10000, 0, 0, 0, 19'd2, 0, 0);
    send(18'h00003, 0, 18'h10000, 0, 0, 1, 19'd2, 0, 0);
    send(18'h3FFFF, 0, 18'h10000, 0, 0, 0, 19'd0, 0, 0);
    send(18'h3FFFF, 0, 18'h10000, 0, 0, 1, 19'd0, 0, 0);
    idle(4);

    // saturation
    send(18'h20000, 18'h20000, 18'h20000, 18'h20000, 0, 0, 19'd0, 19'd262143, 1);
    send(18'h20000, 18'h20000, 18'h20000, 18'h20000, 1, 0, 19'd262143, 19'd0, 1);
    send(18'h20000, 18'h20000, 18'h20000, 18'h1FFFF, 0, 0, 19'd262143, 19'd1, 0);
    idle(4);

    // conjugate mode alternating every sample
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send(18'h10000, 18'h10000, 18'h10000, 18'h10000, 0, 0, 19'd0, 19'd65536, 0);
      else            send(18'h10000, 18'h10000, 18'h10000, 18'h10000, 1, 0, 19'd65536, 19'd0, 0);
    end
    idle(4);

    // backpressure window while streaming 10 random samples
    sent = 0;
    for (int i = 0; i < 24; i++) begin
      st_mready = !(i >= 4 && i <= 9);
      st_valid = (sent < 10);
      rand_stage();
      cycle();
      if (in_fire) sent++;
    end
    chk("bp_sent", 64'(sent), 10);
    st_mready = 1'b1;
    idle(4);

    // reset with three samples in flight, output stalled
    st_mready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1;
      rand_stage();
      cycle();
    end
    idle(1);
    chk("pre_rst_valid", m_valid_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_mid_valid", m_valid_o, 0);
    chk("rst_mid_data", {data_i_o, data_q_o}, 0);
    chk("rst_mid_sat", sat_o, 0);
    exp_q.delete();
    cyc_q.delete();
    held_v = 1'b0;
    @(negedge clk_i);
    #2 rst_n_i = 1'b1;
    st_mready = 1'b1;
    st_valid = 1'b1;
    rand_stage();
    cycle();
    chk("post_rst_accept", in_fire, 1);
    idle(5);

    // randomized traffic with random bubbles and stalls
    for (int i = 0; i < 400; i++) begin
      st_valid = ($urandom_range(0, 9) < 8);
      st_mready = ($urandom_range(0, 9) < 7);
      rand_stage();
      cycle();
    end

    // bounded drain
    st_mready = 1'b1;
    st_valid = 1'b0;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle();
    chk("drain_left", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
